csa_pipelined_multi_adder: RTL



---
 rtl/csa_pipelined_multi_adder_if.sv | 15 +
 rtl/csa_pipelined_multi_adder.sv | 70 +++++++
 2 files changed

// File: rtl/csa_pipelined_multi_adder_if.sv
// csa_pipelined_multi_adder_if: valid/ready operand bus in, sum bus out
interface csa_pipelined_multi_adder_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 3
);
  localparam int SUM_W = WIDTH + $clog2(NUM_OPS);
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_OPS*WIDTH-1:0] ops_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [SUM_W-1:0]         sum_out;
  modport master(output in_valid, ops_in, out_ready, input in_ready, out_valid, sum_out);
  modport slave(input in_valid, ops_in, out_ready, output in_ready, out_valid, sum_out);
endinterface

// File: rtl/csa_pipelined_multi_adder.sv
// csa_pipelined_multi_adder: pipelined Wallace tree of 3:2 CSA levels followed by a registered CPA
module csa_pipelined_multi_adder #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 3,
  parameter int SIGNED  = 0
) (
  input logic clk,
  input logic rst_n,
  csa_pipelined_multi_adder_if.slave bus
);
  localparam int SUM_W = WIDTH + $clog2(NUM_OPS);
  // vector count entering tree level l
  function automatic int cnt(int l);
    int n = NUM_OPS;
    for (int i = 0; i < l; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction
  function automatic int nlev();
    int l = 0;
    for (int i = 0; i < 16; i++) if (cnt(i) > 2) l = i + 1;
    return l;
  endfunction
  localparam int LEVELS = nlev();
  localparam int LAT    = LEVELS + 1;
  typedef logic [NUM_OPS-1:0][SUM_W-1:0] vec_t;
  // one CSA level: groups of three become sum/carry pairs, leftovers shift down unchanged, unused slots stay 0
  function automatic vec_t reduce(vec_t a, int n);
    vec_t r = '0;
    int g = n / 3;
    for (int k = 0; k < NUM_OPS / 3; k++)
      if (k < g) begin
        r[2*k]   = a[3*k] ^ a[3*k+1] ^ a[3*k+2];
        r[2*k+1] = ((a[3*k] & a[3*k+1]) | (a[3*k] & a[3*k+2]) | (a[3*k+1] & a[3*k+2])) << 1;
      end
    for (int j = 0; j < NUM_OPS; j++) if (j >= 3 * g && j < n) r[j-g] = a[j];
    return r;
  endfunction
  vec_t             ext;
  vec_t             nxt  [LEVELS];
  vec_t             pipe [LEVELS];
  logic [SUM_W-1:0] sum_q;
  logic [LAT-1:0]   v;
  logic             advance;
  assign advance       = bus.out_ready | ~v[LAT-1];
  assign bus.in_ready  = advance;
  assign bus.out_valid = v[LAT-1];
  assign bus.sum_out   = sum_q;
  // widen each operand to the full result width, sign- or zero-extended
  always_comb begin
    ext = '0;
    for (int k = 0; k < NUM_OPS; k++)
      ext[k] = {{(SUM_W-WIDTH){SIGNED != 0 && bus.ops_in[k*WIDTH+WIDTH-1]}}, bus.ops_in[k*WIDTH +: WIDTH]};
  end
  // next contents of every level register: level 0 from inputs, level l from register l-1
  always_comb begin
    nxt[0] = reduce(ext, cnt(0));
    for (int l = 1; l < LEVELS; l++) nxt[l] = reduce(pipe[l-1], cnt(l));
  end
  // pipeline shifts as a whole on advance and freezes otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v     <= '0;
      pipe  <= '{default: '0};
      sum_q <= '0;
    end else if (advance) begin
      v     <= {v[LAT-2:0], bus.in_valid};
      pipe  <= nxt;
      sum_q <= pipe[LEVELS-1][0] + pipe[LEVELS-1][1];
    end
endmodule
